// File: rtl/fp_fmt_pkg.sv
// Format codes and lane-placement helpers shared by the FP multiplier operand
// packer and the downstream unpacker.
package fp_fmt_pkg;

    localparam int FMT_CFG_W = 3;

    typedef enum logic [FMT_CFG_W-1:0] {
        FMT_FP32     = 3'd0,
        FMT_TF32     = 3'd1,
        FMT_FP16     = 3'd2,
        FMT_BF16     = 3'd3,
        FMT_FP8_E4M3 = 3'd4,
        FMT_FP8_E5M2 = 3'd5
    } fp_fmt_e;

    // Zero marks an unsupported code.
    function automatic logic [2:0] lanes_per_word(input logic [FMT_CFG_W-1:0] cfg);
        case (cfg)
            FMT_FP32, FMT_TF32:         return 3'd1;
            FMT_FP16, FMT_BF16:         return 3'd2;
            FMT_FP8_E4M3, FMT_FP8_E5M2: return 3'd4;
            default:                    return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [31:0] elem,
                                                input logic [1:0]  idx,
                                                input logic [FMT_CFG_W-1:0] cfg);
        logic [31:0] r;
        r = word;
        case (cfg)
            FMT_FP32:                   r = elem;
            FMT_TF32:                   r = {elem[18:0], 13'b0};
            FMT_FP16, FMT_BF16:         r[{idx[0], 4'b0} +: 16] = elem[15:0];
            FMT_FP8_E4M3, FMT_FP8_E5M2: r[{idx, 3'b0} +: 8] = elem[7:0];
            default:                    r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_operand_packer_assembler.sv
// Per-operand word assembly: holds the partial word, merges the incoming
// element into its lane and produces the lane mask for a closing word.
module fp_lane_assembler
    import fp_fmt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [1:0]           idx,
    input  logic [FMT_CFG_W-1:0] cfg,
    input  logic [31:0]          elem,
    input  logic [1:0]           fill,
    output logic [31:0]          held,
    output logic [31:0]          merged,
    output logic [3:0]           mask
);

    logic [31:0] asm_word;

    assign held   = asm_word;
    assign merged = lane_insert(asm_word, elem, idx, cfg);

    // fill is the index of the highest populated lane
    always_comb begin
        mask = 4'b0001;
        case (fill)
            2'd0: mask = 4'b0001;
            2'd1: mask = 4'b0011;
            2'd2: mask = 4'b0111;
            2'd3: mask = 4'b1111;
            default: mask = 4'b0001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            asm_word <= '0;
        else if (load)
            asm_word <= merged;
    end

endmodule

// File: rtl/fp_mul_operand_packer.sv
// Packs scalar FP operand pairs into 32-bit lane words for the multi-format
// multiplier, with a single registered output stage.
module fp_mul_operand_packer
    import fp_fmt_pkg::*;
#(
    parameter int CONFIG_WIDTH = FMT_CFG_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [31:0]             IN_A,
    input  logic [31:0]             IN_B,
    input  logic [CONFIG_WIDTH-1:0] IN_CFG,
    input  logic                    IN_LAST,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [31:0]             OUT_IN1,
    output logic [31:0]             OUT_IN2,
    output logic [CONFIG_WIDTH-1:0] OUT_CONFIG_FP,
    output logic [3:0]              OUT_LANE_MASK,
    output logic                    ILLEGAL_CFG
);

    logic [1:0]              cnt;
    logic [CONFIG_WIDTH-1:0] asm_cfg;
    logic [2:0]              lanes;
    logic legal, closing, flush_pending, slot_free;
    logic accept, take, close, grow, flush;
    logic [1:0]  fill;
    logic [31:0] held1, held2, merged1, merged2;
    logic [3:0]  mask1, mask2;

    assign lanes     = lanes_per_word(IN_CFG);
    assign legal     = (lanes != 3'd0);
    assign closing   = legal & (({1'b0, cnt} == lanes - 3'd1) | IN_LAST);
    // Unsupported codes are dropped, so they never force a flush of the partial word.
    assign flush_pending = IN_VALID & legal & (cnt != 2'd0) & (IN_CFG != asm_cfg);
    assign slot_free = !OUT_VALID | OUT_READY;

    assign IN_READY = !RST & !flush_pending & (!closing | slot_free);

    assign accept = IN_VALID & IN_READY;
    assign take   = accept & legal;
    assign close  = take & closing;
    assign grow   = take & !closing;
    assign flush  = flush_pending & slot_free & !RST;
    assign fill   = flush ? cnt - 2'd1 : cnt;

    fp_lane_assembler u_op1 (
        .clk(CLK), .rst(RST), .load(grow), .clear(close | flush),
        .idx(cnt), .cfg(IN_CFG), .elem(IN_A), .fill(fill),
        .held(held1), .merged(merged1), .mask(mask1)
    );

    fp_lane_assembler u_op2 (
        .clk(CLK), .rst(RST), .load(grow), .clear(close | flush),
        .idx(cnt), .cfg(IN_CFG), .elem(IN_B), .fill(fill),
        .held(held2), .merged(merged2), .mask(mask2)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt         <= '0;
            asm_cfg     <= '0;
            ILLEGAL_CFG <= 1'b0;
        end else begin
            if (close || flush)
                cnt <= '0;
            else if (grow)
                cnt <= cnt + 2'd1;
            if (grow)
                asm_cfg <= IN_CFG;
            if (accept && !legal)
                ILLEGAL_CFG <= 1'b1;
        end
    end

    // Both assemblers see the same fill, so their masks agree lane for lane.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID     <= 1'b0;
            OUT_IN1       <= '0;
            OUT_IN2       <= '0;
            OUT_CONFIG_FP <= '0;
            OUT_LANE_MASK <= '0;
        end else if (close) begin
            OUT_VALID     <= 1'b1;
            OUT_IN1       <= merged1;
            OUT_IN2       <= merged2;
            OUT_CONFIG_FP <= IN_CFG;
            OUT_LANE_MASK <= mask1 & mask2;
        end else if (flush) begin
            OUT_VALID     <= 1'b1;
            OUT_IN1       <= held1;
            OUT_IN2       <= held2;
            OUT_CONFIG_FP <= asm_cfg;
            OUT_LANE_MASK <= mask1 & mask2;
        end else if (OUT_READY) begin
            OUT_VALID     <= 1'b0;
        end
    end

endmodule
